// File: rtl/mmio_uart_tx_pkg.sv
// Shared types and constants for the memory-mapped UART transmitter.
package mmio_uart_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    localparam logic [31:0] DEFAULT_TX_ADDR = 32'h1000_0000;
    localparam int          DATA_BITS       = 8;

endpackage

// File: rtl/mmio_uart_tx_sync_fifo.sv
// Synchronous byte FIFO with occupancy counter; push while full is honoured only alongside a pop.
module sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign rdata = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Store-mapped UART transmitter: a store to TX_ADDR queues a byte, the FSM serialises 8N1 frames.
//
// state    | meaning
// ST_IDLE  | line high, waiting for a queued byte
// ST_START | start bit (0) on the line
// ST_DATA  | data bit bit_idx on the line, LSB first
// ST_STOP  | stop bit (1); chains straight into the next start if bytes remain
module mmio_uart_tx
    import mmio_uart_tx_pkg::*;
#(
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 8,
    parameter logic [31:0] TX_ADDR      = DEFAULT_TX_ADDR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWriteM,
    input  logic [31:0] DataAdrM,
    input  logic [31:0] WriteDataM,
    output logic        tx,
    output logic        busy,
    output logic        fifo_full,
    output logic        overflow
);

    localparam int                BAUD_W    = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LOAD = BAUD_W'(CLKS_PER_BIT - 1);

    tx_state_e                   state, state_d;
    logic [BAUD_W-1:0]           baud_cnt, baud_cnt_d;
    logic [2:0]                  bit_idx, bit_idx_d;
    logic [7:0]                  shift_byte;
    logic                        tx_d;
    logic                        baud_tc;
    logic                        store_hit;
    logic                        fifo_push;
    logic                        fifo_pop;
    logic                        fifo_empty;
    logic [7:0]                  fifo_rdata;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic                        unused_bits;

    assign unused_bits = ^{WriteDataM[31:8], fifo_count};

    assign store_hit = MemWriteM && (DataAdrM == TX_ADDR);
    assign fifo_push = store_hit && (!fifo_full || fifo_pop);
    assign busy      = (state != ST_IDLE) || !fifo_empty;
    assign baud_tc   = (baud_cnt == '0);

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .wdata (WriteDataM[7:0]),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        state_d    = state;
        baud_cnt_d = baud_cnt;
        bit_idx_d  = bit_idx;
        fifo_pop   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_d    = ST_START;
                    fifo_pop   = 1'b1;
                    baud_cnt_d = BAUD_LOAD;
                end
            end
            ST_START: begin
                if (baud_tc) begin
                    state_d    = ST_DATA;
                    baud_cnt_d = BAUD_LOAD;
                    bit_idx_d  = '0;
                end else begin
                    baud_cnt_d = baud_cnt - 1'b1;
                end
            end
            ST_DATA: begin
                if (baud_tc) begin
                    baud_cnt_d = BAUD_LOAD;
                    bit_idx_d  = bit_idx + 3'd1;
                    if (bit_idx == 3'(DATA_BITS - 1)) begin
                        state_d = ST_STOP;
                    end
                end else begin
                    baud_cnt_d = baud_cnt - 1'b1;
                end
            end
            ST_STOP: begin
                if (baud_tc) begin
                    if (!fifo_empty) begin
                        state_d    = ST_START;
                        fifo_pop   = 1'b1;
                        baud_cnt_d = BAUD_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    baud_cnt_d = baud_cnt - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // tx is registered from next-state so the line never glitches between bits.
    always_comb begin
        tx_d = 1'b1;
        if (state_d == ST_START) begin
            tx_d = 1'b0;
        end else if (state_d == ST_DATA) begin
            tx_d = shift_byte[bit_idx_d];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            shift_byte <= '0;
            tx         <= 1'b1;
            overflow   <= 1'b0;
        end else begin
            state    <= state_d;
            baud_cnt <= baud_cnt_d;
            bit_idx  <= bit_idx_d;
            tx       <= tx_d;
            if (fifo_pop) begin
                shift_byte <= fifo_rdata;
            end
            if (store_hit && fifo_full && !fifo_pop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Scoreboard bench for mmio_uart_tx: a timing model predicts line/status per cycle, a monitor decodes frames.
module tb_mmio_uart_tx;

    localparam int          CPB   = 4;
    localparam int          DEPTH = 4;
    localparam int          FRAME = 10 * CPB;
    localparam logic [31:0] ADDR  = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemWriteM;
    logic [31:0] DataAdrM;
    logic [31:0] WriteDataM;
    logic        tx;
    logic        busy;
    logic        fifo_full;
    logic        overflow;

    mmio_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH),
        .TX_ADDR      (ADDR)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .MemWriteM  (MemWriteM),
        .DataAdrM   (DataAdrM),
        .WriteDataM (WriteDataM),
        .tx         (tx),
        .busy       (busy),
        .fifo_full  (fifo_full),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] sb_q[$];
    logic [7:0] model_q[$];
    int         t = 0;
    int         free_at = 0;
    int         cur_pop = 0;
    logic [7:0] cur_byte = 8'h00;
    logic       ovf_m = 1'b0;
    logic       mon_abort = 1'b0;
    int         frames_seen = 0;

    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        else if (k <= 8) return b[k-1];
        else return 1'b1;
    endfunction

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, t);
        end
    endfunction

    // Transmitter modelled as: a frame occupies FRAME cycles from its pop edge; next pop no earlier than its end.
    task automatic model_edge(input logic r, input logic we, input logic [31:0] adr, input logic [31:0] wd);
        logic do_pop;
        t++;
        if (r) begin
            model_q.delete();
            sb_q.delete();
            free_at   = t;
            ovf_m     = 1'b0;
            mon_abort = 1'b1;
            return;
        end
        do_pop = (model_q.size() > 0) && (t >= free_at);
        if (do_pop) begin
            cur_byte = model_q.pop_front();
            cur_pop  = t;
            free_at  = t + FRAME;
        end
        if (we && adr == ADDR) begin
            if (model_q.size() < DEPTH) begin
                model_q.push_back(wd[7:0]);
                sb_q.push_back(wd[7:0]);
            end else begin
                ovf_m = 1'b1;
            end
        end
    endtask

    task automatic check_status();
        logic       active;
        logic [3:0] exp;
        active = (t < free_at);
        exp = {active ? frame_bit(cur_byte, (t - cur_pop) / CPB) : 1'b1,
               active || (model_q.size() > 0),
               model_q.size() == DEPTH,
               ovf_m};
        chk("status{tx,busy,full,ovf}", 32'({tx, busy, fifo_full, overflow}), 32'(exp));
    endtask

    task automatic cycle(input logic r, input logic we, input logic [31:0] adr, input logic [31:0] wd);
        reset      = r;
        MemWriteM  = we;
        DataAdrM   = adr;
        WriteDataM = wd;
        @(posedge clk);
        model_edge(r, we, adr, wd);
        @(negedge clk);
        check_status();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, ADDR, 32'h0);
    endtask

    task automatic store(input logic [7:0] b);
        logic [31:0] w;
        w = $urandom();
        w[7:0] = b;
        cycle(1'b0, 1'b1, ADDR, w);
    endtask

    // Monitor: detects a start bit, pops the expected byte and checks every cycle of the frame.
    initial begin
        logic [7:0] exp;
        logic [7:0] got;
        int         bad;
        logic       aborted;
        forever begin
            @(negedge clk);
            if (mon_abort) begin
                mon_abort = 1'b0;
                continue;
            end
            if (tx === 1'b0) begin
                chk("frame_was_queued", 32'(sb_q.size() > 0), 32'd1);
                exp = 8'h00;
                if (sb_q.size() > 0) exp = sb_q.pop_front();
                bad = 0;
                got = 8'h00;
                aborted = 1'b0;
                for (int c = 0; c < FRAME; c++) begin
                    if (c > 0) begin
                        @(negedge clk);
                        if (mon_abort) begin
                            mon_abort = 1'b0;
                            aborted = 1'b1;
                            break;
                        end
                    end
                    if (tx !== frame_bit(exp, c / CPB)) bad++;
                    if ((c % CPB) == CPB / 2 && c / CPB >= 1 && c / CPB <= 8) got[c / CPB - 1] = tx;
                end
                if (!aborted) begin
                    frames_seen++;
                    chk("frame_byte", 32'(got), 32'(exp));
                    chk("frame_bad_cycles", 32'(bad), 32'd0);
                end
            end
        end
    end

    initial begin
        int          n0;
        int          guard;
        logic        r;
        logic        we;
        int          sel;
        logic [31:0] adr;
        reset = 1'b1; MemWriteM = 1'b0; DataAdrM = '0; WriteDataM = '0;

        repeat (3) cycle(1'b1, 1'b0, 32'h0, 32'h0);
        chk("reset_state", 32'({tx, busy, fifo_full, overflow}), 32'b1000);

        // Single frame: tx low from the next edge, busy drops 41 edges after the store.
        store(8'h55);
        chk("latency_tx_low", 32'(tx), 32'd1);
        cycle(1'b0, 1'b0, ADDR, 32'h0);
        chk("start_bit_low", 32'(tx), 32'd0);
        idle(45);

        store(8'h41);
        store(8'h42);
        idle(85);

        cycle(1'b0, 1'b1, ADDR + 32'h4, 32'hAA);
        cycle(1'b0, 1'b0, ADDR, 32'hAA);
        chk("ignored_busy", 32'(busy), 32'd0);
        chk("ignored_tx", 32'(tx), 32'd1);
        idle(5);

        n0 = frames_seen;
        for (int i = 0; i < 6; i++) store(8'h10 + 8'(i));
        chk("six_full", 32'(fifo_full), 32'd1);
        chk("six_overflow", 32'(overflow), 32'd1);
        idle(5 * FRAME + 10);
        chk("five_frames", 32'(frames_seen - n0), 32'd5);

        // Abort during data bit 3 with two bytes still queued.
        cycle(1'b1, 1'b0, 32'h0, 32'h0);
        store(8'hE7); store(8'h3C); store(8'h81);
        idle(16);
        n0 = frames_seen;
        cycle(1'b1, 1'b0, 32'h0, 32'h0);
        chk("abort_tx", 32'(tx), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        idle(3 * FRAME);
        chk("no_frames_after_reset", 32'(frames_seen - n0), 32'd0);

        // Store lands on the very edge that pops a full FIFO.
        for (int i = 0; i < 5; i++) store(8'hA0 + 8'(i));
        chk("full_before_pop", 32'(fifo_full), 32'd1);
        guard = 0;
        while (free_at != t + 1 && guard < 200) begin
            idle(1);
            guard++;
        end
        chk("reached_pop_edge", 32'(free_at == t + 1), 32'd1);
        store(8'hC5);
        chk("full_pop_overflow", 32'(overflow), 32'd0);
        chk("full_pop_still_full", 32'(fifo_full), 32'd1);
        idle(5 * FRAME + 10);
        chk("drained_in_order", 32'(sb_q.size()), 32'd0);

        for (int i = 0; i < 900; i++) begin
            r   = ($urandom_range(0, 299) == 0);
            we  = ($urandom_range(0, 3) == 0);
            sel = $urandom_range(0, 3);
            adr = (sel < 2) ? ADDR : (sel == 2) ? ADDR + 32'h4 : $urandom();
            cycle(r, we, adr, $urandom());
        end

        guard = 0;
        while ((t < free_at || model_q.size() > 0) && guard < 2000) begin
            idle(1);
            guard++;
        end
        idle(2);
        chk("drain_bound", 32'(guard < 2000), 32'd1);
        chk("final_scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
